// File: rtl/uart_rx_if.sv
// CPU/bus side of the UART receiver: buffered word, status flags and read strobe.
interface uart_rx_if #(
   parameter int MAX_WORD_LEN = 9
);
   logic [MAX_WORD_LEN-1:0] data;
   logic                    rd;
   logic                    rxc;
   logic                    ferr;
   logic                    perr;
   logic                    ovr;
   logic                    busy;

   modport master (input data, rxc, ferr, perr, ovr, busy, output rd);
   modport slave  (output data, rxc, ferr, perr, ovr, busy, input rd);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 3-sample majority vote, 5..9 data bits,
// optional parity, 1 or 2 stop bits, one-deep receive buffer with status.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line idle, waiting for rxs=0 (or for rxs=1 after a break)
// S_START  | start bit; a high majority sample is a false start
// S_DATA   | data bits, LSB first, into shreg[bitcnt]
// S_PARITY | parity bit compared against computed parity
// S_STOP1  | first stop bit; commits here when one stop bit is configured
// S_STOP2  | second stop bit; always commits
module uart_rx #(
   parameter int MAX_WORD_LEN = 9,
   parameter int SAMPLE_MID   = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxen,
   input  logic       rx,
   input  logic [3:0] wordlen,
   input  logic [1:0] parity,
   input  logic       stopbits,
   uart_rx_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
   } state_t;

   localparam logic [3:0] TICK_V0 = 4'(SAMPLE_MID - 1);
   localparam logic [3:0] TICK_V1 = 4'(SAMPLE_MID);
   localparam logic [3:0] TICK_S  = 4'(SAMPLE_MID + 1);

   state_t                  state;
   logic                    rx_m;
   logic                    rxs;
   logic [3:0]              tick;
   logic [3:0]              bitcnt;
   logic [3:0]              len_q;
   logic [1:0]              par_q;
   logic                    stop2_q;
   logic [MAX_WORD_LEN-1:0] shreg;
   logic                    v0;
   logic                    v1;
   logic                    ferr_pend;
   logic                    perr_pend;
   logic                    wait_high;

   logic       sample_pt;
   logic       wrap;
   logic       vote;
   logic       par_calc;
   logic       last_stop;
   logic       ferr_final;
   logic [3:0] len_in;
   logic       par_en;

   always_comb begin
      sample_pt  = (tick == TICK_S);
      wrap       = (tick == 4'd15);
      vote       = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
      // Unused upper shreg bits are cleared at start, so a full XOR is safe.
      par_calc   = (^shreg) ^ par_q[1];
      last_stop  = sample_pt && ((state == S_STOP1 && !stop2_q) || state == S_STOP2);
      ferr_final = ferr_pend | ~vote;
      len_in     = (wordlen >= 4'd5 && wordlen <= 4'd9) ? wordlen : 4'd8;
      par_en     = (par_q == 2'b01) || (par_q == 2'b10);
   end

   always_ff @(posedge clk) begin
      if (rst || !rxen) begin
         state     <= S_IDLE;
         rx_m      <= 1'b1;
         rxs       <= 1'b1;
         tick      <= 4'd0;
         bitcnt    <= 4'd0;
         len_q     <= 4'd8;
         par_q     <= 2'b00;
         stop2_q   <= 1'b0;
         shreg     <= '0;
         v0        <= 1'b1;
         v1        <= 1'b1;
         ferr_pend <= 1'b0;
         perr_pend <= 1'b0;
         wait_high <= 1'b0;
         bus.rxc   <= 1'b0;
         bus.ferr  <= 1'b0;
         bus.perr  <= 1'b0;
         bus.ovr   <= 1'b0;
         bus.busy  <= 1'b0;
         if (rst) bus.data <= '0;
      end else begin
         rx_m <= rx;
         rxs  <= rx_m;
         if (state != S_IDLE) tick <= tick + 4'd1;
         if (tick == TICK_V0) v0 <= rxs;
         if (tick == TICK_V1) v1 <= rxs;

         case (state)
            S_IDLE: begin
               if (wait_high) begin
                  if (rxs) wait_high <= 1'b0;
               end else if (!rxs) begin
                  tick      <= 4'd0;
                  len_q     <= len_in;
                  par_q     <= parity;
                  stop2_q   <= stopbits;
                  shreg     <= '0;
                  ferr_pend <= 1'b0;
                  perr_pend <= 1'b0;
                  state     <= S_START;
                  bus.busy  <= 1'b1;
               end
            end
            S_START: begin
               if (sample_pt && vote) begin
                  state    <= S_IDLE;
                  bus.busy <= 1'b0;
               end else if (wrap) begin
                  state  <= S_DATA;
                  bitcnt <= 4'd0;
               end
            end
            S_DATA: begin
               if (sample_pt) shreg[bitcnt] <= vote;
               if (wrap) begin
                  if (bitcnt == len_q - 4'd1) state <= par_en ? S_PARITY : S_STOP1;
                  else bitcnt <= bitcnt + 4'd1;
               end
            end
            S_PARITY: begin
               if (sample_pt && (vote != par_calc)) perr_pend <= 1'b1;
               if (wrap) state <= S_STOP1;
            end
            S_STOP1: begin
               if (sample_pt) begin
                  if (!vote) ferr_pend <= 1'b1;
                  if (!stop2_q) begin
                     state    <= S_IDLE;
                     bus.busy <= 1'b0;
                  end
               end else if (wrap) begin
                  state <= S_STOP2;
               end
            end
            S_STOP2: begin
               if (sample_pt) begin
                  if (!vote) ferr_pend <= 1'b1;
                  state    <= S_IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               bus.busy <= 1'b0;
            end
         endcase

         // A low final stop sample means the line may be in break; re-arm only after it rises.
         if (last_stop) begin
            if (!vote) wait_high <= 1'b1;
            if (!bus.rxc || bus.rd) begin
               bus.data <= shreg;
               bus.ferr <= ferr_final;
               bus.perr <= perr_pend;
               bus.rxc  <= 1'b1;
               bus.ovr  <= 1'b0;
            end else begin
               bus.ovr <= 1'b1;
            end
         end else if (bus.rd && bus.rxc) begin
            bus.rxc <= 1'b0;
            bus.ovr <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are serialised bit by bit, expected
// buffer contents are queued per frame and compared once the frame ends.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxen;
   logic       rx;
   logic [3:0] wordlen;
   logic [1:0] parity;
   logic       stopbits;

   uart_rx_if #(.MAX_WORD_LEN(9)) bus ();

   uart_rx #(.MAX_WORD_LEN(9), .SAMPLE_MID(7)) dut (
      .clk      (clk),
      .rst      (rst),
      .rxen     (rxen),
      .rx       (rx),
      .wordlen  (wordlen),
      .parity   (parity),
      .stopbits (stopbits),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [8:0] data;
      logic       rxc;
      logic       ferr;
      logic       perr;
      logic       ovr;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   rise_off;
   int   commit_off;

   initial begin
      #2_000_000;
      $error("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
   endtask

   task automatic expect_word(input logic [8:0] d, input logic f, input logic p, input logic o);
      exp_t e;
      e.data = d;
      e.rxc  = 1'b1;
      e.ferr = f;
      e.perr = p;
      e.ovr  = o;
      sb.push_back(e);
   endtask

   task automatic check_pop(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         $error("FAIL %s: got empty scoreboard expected entry", name);
      end else begin
         e = sb.pop_front();
         chk({name, "_data"}, 32'(bus.data), 32'(e.data));
         chk({name, "_rxc"},  32'(bus.rxc),  32'(e.rxc));
         chk({name, "_ferr"}, 32'(bus.ferr), 32'(e.ferr));
         chk({name, "_perr"}, 32'(bus.perr), 32'(e.perr));
         chk({name, "_ovr"},  32'(bus.ovr),  32'(e.ovr));
      end
   endtask

   task automatic rd_pulse();
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
      tick();
   endtask

   // Serialise one frame; rx changes just after edge E0 and the final stop
   // sample lands 12 + 16*(bits-1) edges later (2 sync flops + detect + mid-bit vote).
   task automatic send_frame(input logic [8:0] word, input int len, input logic [1:0] par,
                             input logic st2, input bit flip_par, input bit bad_stop,
                             input bit rd_at_commit);
      logic [15:0] fb;
      int          nb;
      logic        pw;
      logic        prev;
      int          c0;
      wordlen  = 4'(len);
      parity   = par;
      stopbits = st2;
      fb    = '0;
      fb[0] = 1'b0;
      pw    = 1'b0;
      for (int i = 0; i < len; i++) begin
         fb[1 + i] = word[i];
         pw        = pw ^ word[i];
      end
      nb = 1 + len;
      if (par == 2'b01 || par == 2'b10) begin
         fb[nb] = pw ^ (par == 2'b10) ^ flip_par;
         nb++;
      end
      fb[nb] = ~bad_stop;
      nb++;
      if (st2) begin
         fb[nb] = 1'b1;
         nb++;
      end
      commit_off = 12 + 16 * (nb - 1);
      rise_off   = -1;
      tick();
      c0   = cyc;
      prev = bus.rxc;
      for (int k = 0; k < nb * 16; k++) begin
         rx     = fb[k / 16];
         bus.rd = rd_at_commit && (k == commit_off - 1);
         tick();
         if (bus.rxc && !prev && rise_off < 0) rise_off = cyc - c0;
         prev = bus.rxc;
      end
      rx     = 1'b1;
      bus.rd = 1'b0;
      idle(4);
   endtask

   // Start bit plus three data bits, leaving the receiver in the middle of DATA.
   task automatic partial_frame();
      wordlen  = 4'd8;
      parity   = 2'b00;
      stopbits = 1'b0;
      tick();
      rx = 1'b0; idle(16);
      rx = 1'b1; idle(16);
      rx = 1'b0; idle(16);
      rx = 1'b1; idle(8);
   endtask

   initial begin
      rst      = 1'b1;
      rxen     = 1'b1;
      rx       = 1'b1;
      bus.rd   = 1'b0;
      wordlen  = 4'd8;
      parity   = 2'b00;
      stopbits = 1'b0;
      idle(3);
      chk("reset_data", 32'(bus.data), 32'h0);
      chk("reset_rxc",  32'(bus.rxc),  32'h0);
      chk("reset_busy", 32'(bus.busy), 32'h0);
      chk("reset_flags", 32'({bus.ferr, bus.perr, bus.ovr}), 32'h0);
      rst = 1'b0;
      idle(4);

      // 8N1 0xA5 and commit latency
      expect_word(9'h0A5, 1'b0, 1'b0, 1'b0);
      send_frame(9'h0A5, 8, 2'b00, 1'b0, 0, 0, 0);
      chk("a5_latency", 32'(rise_off), 32'(commit_off));
      check_pop("a5");
      rd_pulse();
      chk("a5_rd_rxc",  32'(bus.rxc),  32'h0);
      chk("a5_rd_data", 32'(bus.data), 32'h0A5);

      // parity formats, good then flipped parity bit
      expect_word(9'h1C3, 1'b0, 1'b0, 1'b0);
      send_frame(9'h1C3, 9, 2'b10, 1'b1, 0, 0, 0);
      check_pop("9o2");
      rd_pulse();
      expect_word(9'h015, 1'b0, 1'b0, 1'b0);
      send_frame(9'h015, 5, 2'b01, 1'b0, 0, 0, 0);
      check_pop("5e1");
      rd_pulse();
      expect_word(9'h1C3, 1'b0, 1'b1, 1'b0);
      send_frame(9'h1C3, 9, 2'b10, 1'b1, 1, 0, 0);
      check_pop("9o2_bad");
      rd_pulse();
      expect_word(9'h015, 1'b0, 1'b1, 1'b0);
      send_frame(9'h015, 5, 2'b01, 1'b0, 1, 0, 0);
      check_pop("5e1_bad");
      rd_pulse();

      // glitch shorter than the sample window
      wordlen = 4'd8;
      parity  = 2'b00;
      tick();
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      chk("glitch_busy_start", 32'(bus.busy), 32'h1);
      idle(12);
      chk("glitch_busy_end", 32'(bus.busy), 32'h0);
      chk("glitch_rxc",      32'(bus.rxc),  32'h0);
      idle(32);

      // frame error, then cleared by a good frame
      expect_word(9'h03C, 1'b1, 1'b0, 1'b0);
      send_frame(9'h03C, 8, 2'b00, 1'b0, 0, 1, 0);
      check_pop("ferr");
      rd_pulse();
      expect_word(9'h081, 1'b0, 1'b0, 1'b0);
      send_frame(9'h081, 8, 2'b00, 1'b0, 0, 0, 0);
      check_pop("ferr_clear");
      rd_pulse();

      // overrun, then rd coinciding with commit
      expect_word(9'h011, 1'b0, 1'b0, 1'b0);
      send_frame(9'h011, 8, 2'b00, 1'b0, 0, 0, 0);
      check_pop("ovr_first");
      expect_word(9'h011, 1'b0, 1'b0, 1'b1);
      send_frame(9'h022, 8, 2'b00, 1'b0, 0, 0, 0);
      check_pop("ovr_lost");
      expect_word(9'h033, 1'b0, 1'b0, 1'b0);
      send_frame(9'h033, 8, 2'b00, 1'b0, 0, 0, 1);
      check_pop("rd_commit");
      rd_pulse();
      chk("rd_commit_clear", 32'(bus.rxc), 32'h0);

      // break: zero word with ferr, no re-arm while the line stays low
      expect_word(9'h000, 1'b1, 1'b0, 1'b0);
      wordlen = 4'd8;
      parity  = 2'b00;
      tick();
      rx = 1'b0;
      idle(224);
      check_pop("break");
      chk("break_hold_busy", 32'(bus.busy), 32'h0);
      rx = 1'b1;
      idle(32);
      chk("break_release_busy", 32'(bus.busy), 32'h0);
      rd_pulse();

      // synchronous reset mid-DATA
      expect_word(9'h077, 1'b0, 1'b0, 1'b0);
      send_frame(9'h077, 8, 2'b00, 1'b0, 0, 0, 0);
      check_pop("pre_rst");
      partial_frame();
      chk("mid_busy", 32'(bus.busy), 32'h1);
      rst = 1'b1;
      rx  = 1'b1;
      tick();
      chk("rst_data", 32'(bus.data), 32'h0);
      chk("rst_stat", 32'({bus.rxc, bus.ferr, bus.perr, bus.ovr, bus.busy}), 32'h0);
      rst = 1'b0;
      idle(32);
      expect_word(9'h05A, 1'b0, 1'b0, 1'b0);
      send_frame(9'h05A, 8, 2'b00, 1'b0, 0, 0, 0);
      check_pop("post_rst");

      // rxen low mid-frame keeps data only
      partial_frame();
      rxen = 1'b0;
      rx   = 1'b1;
      tick();
      chk("rxen_data", 32'(bus.data), 32'h05A);
      chk("rxen_stat", 32'({bus.rxc, bus.ferr, bus.perr, bus.ovr, bus.busy}), 32'h0);
      rxen = 1'b1;
      idle(32);
      expect_word(9'h0F0, 1'b0, 1'b0, 1'b0);
      send_frame(9'h0F0, 8, 2'b00, 1'b0, 0, 0, 0);
      check_pop("post_rxen");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
